eeprom_prgm_seq: RTL and testbench

//  Program-load sequencer: writes a block of words from an external source into program EEPROM.

---
 rtl/eeprom_prgm_seq_pkg.sv | 64 ++++++
 rtl/eeprom_prgm_seq_wait_timer.sv | 37 +++
 rtl/eeprom_prgm_seq.sv | 145 ++++++++++++++
 tb/tb_eeprom_prgm_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_prgm_seq_pkg.sv
// Shared definitions for the program-load sequencer: state encodings, bus width
// and the Moore decode of per-state control outputs.
package eeprom_prgm_seq_pkg;

  localparam int STATE_W = 3;
  localparam int BUS_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_SET_MAR  = 3'd2,
    ST_SET_DATA = 3'd3,
    ST_WAIT     = 3'd4,
    ST_FINISH   = 3'd5,
    ST_ERROR    = 3'd6
  } state_e;

  typedef struct packed {
    logic prgm;
    logic src_ready;
    logic bus_oe;
    logic we_mar;
    logic we_eeprom;
    logic busy;
    logic done;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.prgm      = 1'b1;
        c.src_ready = 1'b1;
        c.busy      = 1'b1;
      end
      ST_SET_MAR: begin
        c.prgm   = 1'b1;
        c.bus_oe = 1'b1;
        c.we_mar = 1'b1;
        c.busy   = 1'b1;
      end
      ST_SET_DATA: begin
        c.prgm      = 1'b1;
        c.bus_oe    = 1'b1;
        c.we_eeprom = 1'b1;
        c.busy      = 1'b1;
      end
      ST_WAIT: begin
        c.prgm   = 1'b1;
        c.bus_oe = 1'b1;
        c.busy   = 1'b1;
      end
      ST_FINISH: begin
        c.prgm = 1'b1;
        c.done = 1'b1;
        c.busy = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/eeprom_prgm_seq_wait_timer.sv
// Loadable down-counter bounding the wait for EEPROM write completion.
// Saturates at zero; load has priority over decrement.
module eeprom_prgm_seq_wait_timer #(
  parameter int WR_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int CNT_W = (WR_TIMEOUT < 1) ? 1 : $clog2(WR_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WR_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/eeprom_prgm_seq.sv
// Program-load sequencer: streams source words into program EEPROM via the shared
// bus, strobing MAR then EEPROM per word and waiting (bounded) for write completion.
module eeprom_prgm_seq
  import eeprom_prgm_seq_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = BUS_W,
  parameter int WR_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] last_addr_i,
  input  logic              src_valid_i,
  input  logic [DATA_W-1:0] src_data_i,
  output logic              src_ready_o,
  input  logic              ee_done_i,
  output logic              prgm_o,
  output logic              bus_oe_o,
  output logic [DATA_W-1:0] bus_out_o,
  output logic              we_mar_o,
  output logic              we_eeprom_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  ctrl_t               ctrl_q;
  logic [DATA_W-1:0]   bus_q, bus_d;
  logic                active;
  logic                tmr_load, tmr_dec, tmr_zero;

  assign active = (state_q != ST_IDLE) && (state_q != ST_ERROR);

  // Abort overrides everything while a session is running.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    data_d  = data_q;
    err_d   = err_q;
    if (active && abort_i) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start_i && !abort_i) begin
            state_d = ST_FETCH;
            addr_d  = '0;
            last_d  = last_addr_i;
            err_d   = 1'b0;
          end
        end
        ST_FETCH: begin
          if (src_valid_i) begin
            data_d  = src_data_i;
            state_d = ST_SET_MAR;
          end
        end
        ST_SET_MAR:  state_d = ST_SET_DATA;
        ST_SET_DATA: state_d = ST_WAIT;
        ST_WAIT: begin
          if (ee_done_i) begin
            if (addr_q == last_q) begin
              state_d = ST_FINISH;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_FETCH;
            end
          end else if (tmr_zero) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_d)
      ST_SET_MAR:           bus_d = DATA_W'(addr_d);
      ST_SET_DATA, ST_WAIT: bus_d = data_d;
      default:              bus_d = '0;
    endcase
  end

  assign tmr_load = (state_q == ST_SET_DATA) && !abort_i;
  assign tmr_dec  = (state_q == ST_WAIT) && !ee_done_i && !abort_i;

  eeprom_prgm_seq_wait_timer #(
    .WR_TIMEOUT(WR_TIMEOUT)
  ) u_wait_timer (
    .clk_i  (clk_i),
    .rst_i  (clr_i),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  // Outputs are registered from the next-state decode so they track state_q exactly.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      ctrl_q  <= '0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ctrl_q  <= decode_ctrl(state_d);
      bus_q   <= bus_d;
    end
  end

  assign prgm_o      = ctrl_q.prgm;
  assign src_ready_o = ctrl_q.src_ready;
  assign bus_oe_o    = ctrl_q.bus_oe;
  assign we_mar_o    = ctrl_q.we_mar;
  assign we_eeprom_o = ctrl_q.we_eeprom;
  assign busy_o      = ctrl_q.busy;
  assign done_o      = ctrl_q.done;
  assign bus_out_o   = bus_q;
  assign addr_o      = addr_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_eeprom_prgm_seq.sv
// Directed bench for eeprom_prgm_seq: a per-cycle vector table for a 3-word
// session plus hand-written sequences for reset, timeout, stall, abort and a full load.
module tb_eeprom_prgm_seq;

  logic       clk, clr, start, abort, src_valid, ee_done;
  logic [3:0] last_addr;
  logic [7:0] src_data;
  logic       src_ready, prgm, bus_oe, we_mar, we_eeprom, busy, done, err;
  logic [7:0] bus_out;
  logic [3:0] addr;

  int n_cmp = 0;
  int n_bad = 0;

  eeprom_prgm_seq #(
    .ADDR_W(4),
    .DATA_W(8),
    .WR_TIMEOUT(3)
  ) dut (
    .clk_i       (clk),
    .clr_i       (clr),
    .start_i     (start),
    .abort_i     (abort),
    .last_addr_i (last_addr),
    .src_valid_i (src_valid),
    .src_data_i  (src_data),
    .src_ready_o (src_ready),
    .ee_done_i   (ee_done),
    .prgm_o      (prgm),
    .bus_oe_o    (bus_oe),
    .bus_out_o   (bus_out),
    .we_mar_o    (we_mar),
    .we_eeprom_o (we_eeprom),
    .addr_o      (addr),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {prgm, src_ready, bus_oe, we_mar, we_eeprom, busy, done, err, bus_out, addr};

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       ee;
    byte        st;
    logic [7:0] bus;
    logic [3:0] addr;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp,
                     input logic [19:0] msk);
    n_cmp++;
    if ((act & msk) !== (exp & msk)) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (mask %h)", nm, act, exp, msk);
    end
  endtask

  // Expected control bits per state: {prgm,rdy,oe,we_mar,we_ee,busy,done}.
  task automatic check_state(input string nm, input byte st, input logic er,
                             input logic [7:0] bus, input logic [3:0] ad);
    logic [6:0]  c;
    logic [19:0] e, m;
    case (st)
      "F":     c = 7'b1100010;
      "M":     c = 7'b1011010;
      "D":     c = 7'b1010110;
      "W":     c = 7'b1010010;
      "N":     c = 7'b1000011;
      default: c = 7'b0000000;
    endcase
    e = {c, er, bus, ad};
    m = 20'hFFFFF;
    if (!c[4] && st != "I") m[11:4] = 8'h00;
    chk(nm, obs, e, m);
  endtask

  int   idx, mar_cnt, wr_cnt, overlap, steps, done_step;
  logic got_done;
  logic [3:0] done_addr;

  initial begin
    clr = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; ee_done = 1'b0;
    last_addr = 4'd0; src_data = 8'h00;
    #1;
    chk("reset_outputs", obs, 20'h0, 20'hFFFFF);
    step();
    clr = 1'b0;
    step();
    check_state("idle_after_reset", "I", 1'b0, 8'h00, 4'd0);

    // Three-word session, EE_DONE two cycles after each EEPROM strobe.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, "F", 8'h00, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, "M", 8'h00, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, "D", 8'h11, 4'd0};
    vecs[3]  = '{1'b0, 1'b1, 8'h11, 1'b0, "W", 8'h11, 4'd0};
    vecs[4]  = '{1'b0, 1'b1, 8'h11, 1'b0, "W", 8'h11, 4'd0};
    vecs[5]  = '{1'b0, 1'b1, 8'h22, 1'b1, "F", 8'h00, 4'd1};
    vecs[6]  = '{1'b0, 1'b1, 8'h22, 1'b0, "M", 8'h01, 4'd1};
    vecs[7]  = '{1'b0, 1'b1, 8'h22, 1'b0, "D", 8'h22, 4'd1};
    vecs[8]  = '{1'b0, 1'b1, 8'h22, 1'b0, "W", 8'h22, 4'd1};
    vecs[9]  = '{1'b0, 1'b1, 8'h22, 1'b0, "W", 8'h22, 4'd1};
    vecs[10] = '{1'b0, 1'b1, 8'h33, 1'b1, "F", 8'h00, 4'd2};
    vecs[11] = '{1'b0, 1'b1, 8'h33, 1'b0, "M", 8'h02, 4'd2};
    vecs[12] = '{1'b0, 1'b1, 8'h33, 1'b0, "D", 8'h33, 4'd2};
    vecs[13] = '{1'b0, 1'b1, 8'h33, 1'b0, "W", 8'h33, 4'd2};
    vecs[14] = '{1'b0, 1'b1, 8'h33, 1'b0, "W", 8'h33, 4'd2};
    vecs[15] = '{1'b0, 1'b1, 8'h33, 1'b1, "N", 8'h00, 4'd2};
    vecs[16] = '{1'b0, 1'b1, 8'h33, 1'b0, "I", 8'h00, 4'd0};
    last_addr = 4'd2;
    for (int i = 0; i < 17; i++) begin
      start = vecs[i].start; src_valid = vecs[i].valid;
      src_data = vecs[i].data; ee_done = vecs[i].ee;
      step();
      check_state($sformatf("vec%0d", i), vecs[i].st, 1'b0, vecs[i].bus, vecs[i].addr);
    end

    // Write timeout with WR_TIMEOUT=3: four WAIT cycles, then ERROR.
    last_addr = 4'd0; src_valid = 1'b0; ee_done = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    check_state("to_fetch", "F", 1'b0, 8'h00, 4'd0);
    src_valid = 1'b1; src_data = 8'h77;
    step(); src_valid = 1'b0;
    check_state("to_mar", "M", 1'b0, 8'h00, 4'd0);
    step();
    check_state("to_data", "D", 1'b0, 8'h77, 4'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check_state($sformatf("to_wait%0d", i), "W", 1'b0, 8'h77, 4'd0);
    end
    step();
    check_state("to_error", "E", 1'b1, 8'h00, 4'd0);
    step();
    check_state("err_sticky", "E", 1'b1, 8'h00, 4'd0);
    start = 1'b1;
    step(); start = 1'b0;
    check_state("err_restart", "F", 1'b0, 8'h00, 4'd0);
    abort = 1'b1;
    step(); abort = 1'b0;
    check_state("abort_fetch", "I", 1'b0, 8'h00, 4'd0);

    // Source stall: FETCH holds with no strobes and no timeout.
    start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_state($sformatf("stall%0d", i), "F", 1'b0, 8'h00, 4'd0);
    end
    src_valid = 1'b1; src_data = 8'h5A;
    step(); src_valid = 1'b0;
    check_state("stall_mar", "M", 1'b0, 8'h00, 4'd0);
    step();
    check_state("stall_data", "D", 1'b0, 8'h5A, 4'd0);
    abort = 1'b1;
    step(); abort = 1'b0;
    check_state("stall_abort", "I", 1'b0, 8'h00, 4'd0);

    // Abort in WAIT of word 1, with a simultaneous START that must lose.
    last_addr = 4'd3; start = 1'b1;
    step(); start = 1'b0;
    src_valid = 1'b1; src_data = 8'h44;
    step(); step(); step();
    check_state("ab_w0", "W", 1'b0, 8'h44, 4'd0);
    ee_done = 1'b1;
    step(); ee_done = 1'b0;
    check_state("ab_f1", "F", 1'b0, 8'h00, 4'd1);
    src_data = 8'h55;
    step(); step(); step();
    check_state("ab_w1", "W", 1'b0, 8'h55, 4'd1);
    abort = 1'b1; start = 1'b1;
    step(); abort = 1'b0; start = 1'b0;
    check_state("ab_idle", "I", 1'b0, 8'h00, 4'd0);
    start = 1'b1;
    step(); start = 1'b0;
    check_state("ab_restart", "F", 1'b0, 8'h00, 4'd0);

    // CLR asserted mid-cycle during WAIT clears outputs before the next edge.
    step(); step(); step();
    check_state("clr_wait", "W", 1'b0, 8'h55, 4'd0);
    src_valid = 1'b0;
    #2 clr = 1'b1;
    #1 chk("clr_async", obs, 20'h0, 20'hFFFFF);
    step();
    clr = 1'b0;
    step(); step(); step();
    check_state("clr_stays_idle", "I", 1'b0, 8'h00, 4'd0);
    start = 1'b1;
    step(); start = 1'b0;
    check_state("clr_restart", "F", 1'b0, 8'h00, 4'd0);
    abort = 1'b1;
    step(); abort = 1'b0;

    // Full 16-word load at minimum latency; a START mid-session must be ignored.
    last_addr = 4'd15; src_valid = 1'b1; ee_done = 1'b1;
    idx = 0; mar_cnt = 0; wr_cnt = 0; overlap = 0; got_done = 1'b0;
    done_step = 0; done_addr = 4'd0;
    src_data = 8'hA0; start = 1'b1;
    step(); steps = 1; start = 1'b0;
    while (!got_done && steps < 200) begin
      if (we_mar && we_eeprom) overlap++;
      if (we_mar) begin
        chk($sformatf("full_mar%0d", mar_cnt), {12'h0, bus_out}, 20'(mar_cnt), 20'hFFFFF);
        mar_cnt++;
        idx++;
        src_data = 8'hA0 + 8'(idx);
      end
      if (we_eeprom) begin
        chk($sformatf("full_wr%0d", wr_cnt), {12'h0, bus_out}, 20'(8'hA0 + 8'(wr_cnt)), 20'hFFFFF);
        wr_cnt++;
      end
      if (done) begin
        got_done = 1'b1; done_step = steps; done_addr = addr;
      end else begin
        start = (steps == 20);
        step();
        steps++;
      end
    end
    start = 1'b0;
    chk("full_done_seen", {19'h0, got_done}, 20'h1, 20'hFFFFF);
    chk("full_latency", 20'(done_step), 20'd65, 20'hFFFFF);
    chk("full_writes", 20'(wr_cnt), 20'd16, 20'hFFFFF);
    chk("full_final_addr", {16'h0, done_addr}, 20'd15, 20'hFFFFF);
    chk("full_no_overlap", 20'(overlap), 20'd0, 20'hFFFFF);
    src_valid = 1'b0; ee_done = 1'b0;
    step();
    check_state("full_idle", "I", 1'b0, 8'h00, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
